// File: rtl/if_prefetch_unit.sv
// -----------------------------------------------------------------------------
// if_prefetch_unit
//
// Instruction-fetch front end that sits ahead of the core's IF/ID register.
// It issues in-order word requests to instruction memory and keeps returned
// words, together with their PCs, in a small prefetch FIFO. The FIFO head goes
// to decode over a valid/ready handshake. A redirect from execute (branch,
// jump or trap) flushes the FIFO and restarts fetch at the new address.
// Responses to requests issued before the redirect are still in flight; they
// are consumed and discarded in the DRAIN state.
//
// Optional feature macro: IF_STATIC_PRED_EN
//   Defined     : static backward-taken/forward-not-taken prediction on push.
//                 JAL and backward conditional branches are tagged
//                 pred_taken=1, and fetch is steered to pc+imm internally.
//   Not defined : purely sequential fetch, o_pred_taken is tied to 0.
//
// Parameters
//   RESET_PC    first fetch address after reset
//   FIFO_DEPTH  prefetch entries (power of 2, >= 2); also caps outstanding reqs
//
// Ports
//   clk, rst_n        clock (posedge) / asynchronous active-low reset
//   o_imem_req        request valid toward instruction memory
//   o_imem_addr       word-aligned request address
//   i_imem_gnt        request accepted this cycle (req & gnt = issued)
//   i_imem_rvalid     in-order response valid
//   i_imem_rdata      response instruction word
//   i_redirect        flush and restart fetch at i_redirect_addr
//   i_redirect_addr   new fetch PC
//   o_valid           {o_pc, o_instr} valid toward decode
//   i_ready           decode accepts the head entry
//   o_pc, o_instr     head entry PC and instruction word
//   o_pred_taken      head entry was predicted taken
//   o_redirect_misal  one-cycle pulse: redirect target had addr[1:0] != 0
// -----------------------------------------------------------------------------
module if_prefetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_addr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_pred_taken,
  output logic        o_redirect_misal
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_r;
  state_t             state_nxt_s;
  logic [31:0]        fetch_pc_r;   // address of the next request to issue
  logic [31:0]        resp_pc_r;    // PC belonging to the next accepted response
  logic [CNT_W-1:0]   outst_r;      // requests granted but not yet answered
  logic [CNT_W-1:0]   count_r;      // valid FIFO entries
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [31:0]        pc_mem_r    [FIFO_DEPTH];
  logic [31:0]        instr_mem_r [FIFO_DEPTH];
  logic               misal_r;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic               req_s;
  logic               issue_s;
  logic               rsp_s;
  logic               push_s;
  logic               pop_s;
  logic [CNT_W-1:0]   outst_nxt_s;
  logic [CNT_W:0]     occupancy_s;
  logic               pred_hit_s;
  logic [31:0]        pred_target_s;
  logic               int_redir_s;
  logic               redir_s;
  logic [31:0]        redir_tgt_s;

  assign issue_s = req_s & i_imem_gnt;
  // A response with nothing outstanding is stray and ignored entirely.
  assign rsp_s   = i_imem_rvalid & (outst_r != CNT_ZERO);
  // Responses are stored only in RUN; an external redirect discards the
  // response arriving in the same cycle.
  assign push_s  = rsp_s & (state_r == ST_RUN) & ~i_redirect;
  assign pop_s   = (count_r != CNT_ZERO) & i_ready & ~i_redirect;

  assign outst_nxt_s = outst_r
                     + (issue_s ? CNT_ONE : CNT_ZERO)
                     - (rsp_s   ? CNT_ONE : CNT_ZERO);

  assign occupancy_s = {1'b0, count_r} + {1'b0, outst_r};

`ifdef IF_STATIC_PRED_EN
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [31:0] j_imm_s;
  logic [31:0] b_imm_s;
  logic [CNT_W-1:0] pred_mem_unused_s;
  logic        pred_mem_r [FIFO_DEPTH];

  assign j_imm_s = {{12{i_imem_rdata[31]}}, i_imem_rdata[19:12], i_imem_rdata[20],
                    i_imem_rdata[30:21], 1'b0};
  assign b_imm_s = {{20{i_imem_rdata[31]}}, i_imem_rdata[7], i_imem_rdata[30:25],
                    i_imem_rdata[11:8], 1'b0};
  assign pred_mem_unused_s = CNT_ZERO;

  // Static BTFN decision on the incoming word: JAL always, branches when backward.
  always_comb begin
    pred_hit_s    = 1'b0;
    pred_target_s = resp_pc_r;
    if (i_imem_rdata[6:0] == OPC_JAL) begin
      pred_hit_s    = 1'b1;
      pred_target_s = resp_pc_r + j_imm_s;
    end else if ((i_imem_rdata[6:0] == OPC_BRANCH) && i_imem_rdata[31]) begin
      pred_hit_s    = 1'b1;
      pred_target_s = resp_pc_r + b_imm_s;
    end else begin
      pred_hit_s    = 1'b0;
      pred_target_s = resp_pc_r;
    end
  end

  // Prediction tag storage, written alongside the PC/instruction entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_mem_r <= '{default: 1'b0};
    end else if (push_s) begin
      pred_mem_r[wr_ptr_r] <= pred_hit_s;
    end else begin
      pred_mem_r <= pred_mem_r;
    end
  end

  assign o_pred_taken = pred_mem_r[rd_ptr_r];
`else
  assign pred_hit_s    = 1'b0;
  assign pred_target_s = 32'h0000_0000;
  assign o_pred_taken  = 1'b0;
`endif

  // Internal redirect behaves like an external one except that the entry
  // carrying the prediction (and everything older) stays in the FIFO.
  assign int_redir_s = push_s & pred_hit_s;
  assign redir_s     = i_redirect | int_redir_s;

  // External redirect has priority over the internally predicted target.
  always_comb begin
    redir_tgt_s = pred_target_s;
    if (i_redirect) begin
      redir_tgt_s = i_redirect_addr;
    end else begin
      redir_tgt_s = pred_target_s;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; DRAIN lasts until every stale response has come back.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_BOOT: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (redir_s && (outst_nxt_s != CNT_ZERO)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (outst_nxt_s == CNT_ZERO) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_BOOT;
      end
    endcase
  end

  // Output logic: request only while buffered + in-flight words leave a free slot,
  // which is what makes FIFO overflow impossible.
  always_comb begin
    req_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (occupancy_s < DEPTH_C) begin
          req_s = 1'b1;
        end else begin
          req_s = 1'b0;
        end
      end
      ST_BOOT:  req_s = 1'b0;
      ST_DRAIN: req_s = 1'b0;
      default:  req_s = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Fetch/response address tracking
  // ---------------------------------------------------------------------------

  // Fetch PC, response PC, outstanding counter and misalignment pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      outst_r    <= CNT_ZERO;
      misal_r    <= 1'b0;
    end else begin
      outst_r <= outst_nxt_s;
      misal_r <= redir_s & (redir_tgt_s[1:0] != 2'b00);
      if (redir_s) begin
        // All responses still in flight get dropped, so the next accepted
        // response is the first word fetched from the new target.
        fetch_pc_r <= {redir_tgt_s[31:2], 2'b00};
        resp_pc_r  <= {redir_tgt_s[31:2], 2'b00};
      end else begin
        if (issue_s) begin
          fetch_pc_r <= fetch_pc_r + 32'd4;
        end else begin
          fetch_pc_r <= fetch_pc_r;
        end
        if (push_s) begin
          resp_pc_r <= resp_pc_r + 32'd4;
        end else begin
          resp_pc_r <= resp_pc_r;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO
  // ---------------------------------------------------------------------------

  // FIFO pointers, occupancy and entry storage; external redirect empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r    <= {PTR_W{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= CNT_ZERO;
      pc_mem_r    <= '{default: 32'h0000_0000};
      instr_mem_r <= '{default: 32'h0000_0000};
    end else if (i_redirect) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]    <= resp_pc_r;
        instr_mem_r[wr_ptr_r] <= i_imem_rdata;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_r
               + (push_s ? CNT_ONE : CNT_ZERO)
               - (pop_s  ? CNT_ONE : CNT_ZERO);
    end
  end

  assign o_imem_req       = req_s;
  assign o_imem_addr      = fetch_pc_r;
  assign o_valid          = (count_r != CNT_ZERO);
  assign o_pc             = pc_mem_r[rd_ptr_r];
  assign o_instr          = instr_mem_r[rd_ptr_r];
  assign o_redirect_misal = misal_r;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Directed bench for if_prefetch_unit: a cycle table covering sequential fetch,
// a decode stall, and a misaligned redirect, plus hand-written sequences for
// DRAIN after a redirect, fetch_pc wrap, reset during DRAIN and (when the
// prediction macro is defined) a backward branch.
module tb_if_prefetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt = 1'b1;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = 32'h0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_addr = 32'h0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        o_pred_taken;
  logic        o_redirect_misal;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] mem_q [$];
  logic        rsp_en = 1'b1;

  always #5 clk = ~clk;

  if_prefetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect), .i_redirect_addr(i_redirect_addr),
    .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc), .o_instr(o_instr),
    .o_pred_taken(o_pred_taken), .o_redirect_misal(o_redirect_misal)
  );

  // Memory contents: ADDI-shaped words derived from the address.
  function automatic logic [31:0] instr_of(input logic [31:0] a);
`ifdef IF_STATIC_PRED_EN
    if (a == 32'h0000_0020) return 32'hFE00_08E3;  // beq x0,x0,-16
`endif
    return {a[26:2], 7'h13};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: record a grant, then present the oldest pending response (1-cycle memory).
  task automatic tick();
    logic        issued;
    logic [31:0] a;
    issued = o_imem_req & i_imem_gnt;
    a      = o_imem_addr;
    @(posedge clk);
    #1;
    if (issued) mem_q.push_back(a);
    if (rsp_en && (mem_q.size() > 0)) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = instr_of(mem_q.pop_front());
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'h0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_ready = 1'b1; i_redirect = 1'b0; i_redirect_addr = 32'h0; i_imem_gnt = 1'b1;
    i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0; rsp_en = 1'b1;
    mem_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},   {31'h0, o_imem_req},       32'h0);
    check({tag, "_addr"},  o_imem_addr,               32'h0);
    check({tag, "_valid"}, {31'h0, o_valid},          32'h0);
    check({tag, "_pc"},    o_pc,                      32'h0);
    check({tag, "_instr"}, o_instr,                   32'h0);
    check({tag, "_pred"},  {31'h0, o_pred_taken},     32'h0);
    check({tag, "_misal"}, {31'h0, o_redirect_misal}, 32'h0);
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] raddr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        exp_misal;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rd, input logic [31:0] ra,
                              input logic rq, input logic [31:0] ad, input logic v,
                              input logic [31:0] pc, input logic ms);
    vec_t t;
    t.ready = rdy; t.redir = rd; t.raddr = ra; t.exp_req = rq; t.exp_addr = ad;
    t.exp_valid = v; t.exp_pc = pc; t.exp_misal = ms;
    return t;
  endfunction

  vec_t vecs [21];

  initial begin
    // Vectors start at the first edge after reset release (BOOT -> RUN).
    vecs[0]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h00,  1'b0, 32'h0,   1'b0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h04,  1'b0, 32'h0,   1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h08,  1'b1, 32'h00,  1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h0C,  1'b1, 32'h04,  1'b0);
    // Decode stalls for 10 cycles: FIFO fills to 4 and requests stop.
    vecs[4]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h04,  1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 32'h14,  1'b1, 32'h04,  1'b0);
    for (int i = 6; i < 14; i++)
      vecs[i] = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h14,  1'b1, 32'h04,  1'b0);
    vecs[14] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h08,  1'b0);
    vecs[15] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h0C,  1'b0);
    vecs[16] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h1C,  1'b1, 32'h10,  1'b0);
    // Misaligned redirect with one request in flight: one cycle of DRAIN.
    vecs[17] = mk(1'b1, 1'b1, 32'h102, 1'b0, 32'h100, 1'b0, 32'h0,   1'b1);
    vecs[18] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0,   1'b0);
    vecs[19] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0,   1'b0);
    vecs[20] = mk(1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100, 1'b0);

    // ---- reset state ----
    #2 rst_n = 1'b0;
    #1 check_reset_values("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("boot_no_req", {31'h0, o_imem_req}, 32'h0);

    // ---- table: sequential fetch, stall, misaligned redirect ----
    for (int i = 0; i < 21; i++) begin
      i_ready = vecs[i].ready;
      i_redirect = vecs[i].redir;
      i_redirect_addr = vecs[i].raddr;
      tick();
      i_redirect = 1'b0;
      check($sformatf("v%0d_req", i),   {31'h0, o_imem_req},       {31'h0, vecs[i].exp_req});
      check($sformatf("v%0d_addr", i),  o_imem_addr,               vecs[i].exp_addr);
      check($sformatf("v%0d_valid", i), {31'h0, o_valid},          {31'h0, vecs[i].exp_valid});
      check($sformatf("v%0d_misal", i), {31'h0, o_redirect_misal}, {31'h0, vecs[i].exp_misal});
      check($sformatf("v%0d_pred", i),  {31'h0, o_pred_taken},     32'h0);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_pc", i),    o_pc,    vecs[i].exp_pc);
        check($sformatf("v%0d_instr", i), o_instr, instr_of(vecs[i].exp_pc));
      end
    end

    // ---- redirect with 3 requests outstanding ----
    begin
      int drops;
      int steps;
      do_reset();
      rsp_en = 1'b0;
      repeat (4) tick();
      check("d_pre_req", {31'h0, o_imem_req}, 32'h1);
      check("d_pre_addr", o_imem_addr, 32'h0C);
      i_imem_gnt = 1'b0; i_redirect = 1'b1; i_redirect_addr = 32'h100;
      tick();
      i_imem_gnt = 1'b1; i_redirect = 1'b0;
      check("d_req_off", {31'h0, o_imem_req}, 32'h0);
      check("d_valid_off", {31'h0, o_valid}, 32'h0);
      rsp_en = 1'b1;
      drops = 0;
      steps = 0;
      while (!o_imem_req && steps < 20) begin
        if (i_imem_rvalid) drops++;
        tick();
        steps++;
        check("d_no_stale", {31'h0, o_valid}, 32'h0);
      end
      check("d_timeout", {31'h0, o_imem_req}, 32'h1);
      check("d_drops", drops, 32'd3);
      check("d_addr", o_imem_addr, 32'h100);
      tick();
      tick();
      check("d_valid", {31'h0, o_valid}, 32'h1);
      check("d_pc", o_pc, 32'h100);
      check("d_instr", o_instr, instr_of(32'h100));
    end

    // ---- fetch_pc wraps from FFFF_FFFC to 0 ----
    begin
      int steps;
      i_redirect = 1'b1; i_redirect_addr = 32'hFFFF_FFF8;
      tick();
      i_redirect = 1'b0;
      steps = 0;
      while (!o_imem_req && steps < 20) begin
        tick();
        steps++;
      end
      check("w_addr0", o_imem_addr, 32'hFFFF_FFF8);
      tick();
      check("w_addr1", o_imem_addr, 32'hFFFF_FFFC);
      tick();
      check("w_addr2", o_imem_addr, 32'h0000_0000);
      check("w_pc", o_pc, 32'hFFFF_FFF8);
    end

    // ---- reset asserted during DRAIN ----
    do_reset();
    rsp_en = 1'b0;
    repeat (3) tick();
    i_redirect = 1'b1; i_redirect_addr = 32'h200;
    tick();
    i_redirect = 1'b0;
    check("r_drain_req", {31'h0, o_imem_req}, 32'h0);
    #2 rst_n = 1'b0;
    #1 check_reset_values("rmid");
    mem_q.delete();
    i_imem_rvalid = 1'b0;
    rsp_en = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("r_boot", {31'h0, o_imem_req}, 32'h0);
    tick();
    check("r_req", {31'h0, o_imem_req}, 32'h1);
    check("r_addr", o_imem_addr, 32'h0);
    tick();
    tick();
    check("r_valid", {31'h0, o_valid}, 32'h1);
    check("r_pc", o_pc, 32'h0);

`ifdef IF_STATIC_PRED_EN
    // ---- backward BEQ at 0x20 predicted taken to 0x10 ----
    begin
      int steps;
      do_reset();
      steps = 0;
      while (!(o_valid && o_pc == 32'h20) && steps < 40) begin
        tick();
        steps++;
      end
      check("p_found", {31'h0, o_valid}, 32'h1);
      check("p_pc", o_pc, 32'h20);
      check("p_taken", {31'h0, o_pred_taken}, 32'h1);
      tick();
      steps = 0;
      while (!o_valid && steps < 20) begin
        tick();
        steps++;
      end
      check("p_next_pc", o_pc, 32'h10);
      check("p_next_pred", {31'h0, o_pred_taken}, 32'h0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
